hamming_enc_stream: RTL and testbench
=====================================

Name: hamming_enc_stream

Overview:
- Streaming single-error-correcting Hamming encoder, IP_BIT data bits -> (IP_BIT+4)-bit codeword; transmit-side counterpart of the team's Hamming decoder soft IP.
- Registered parity generation feeds a 2-entry output FIFO with valid/ready handshake on both sides, so a decoder-side consumer can apply backpressure.
- Codeword format is bit-exact with the decoder input format.

Parameters:
- IP_BIT, 5, data word width; legal range 5..11 (codeword width N = IP_BIT+4, 9..15).

Ports:
- clk, input, 1, single clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_data is valid this cycle.
- in_data, input, IP_BIT, data word.
- in_ready, output, 1, block can accept a word this cycle.
- out_valid, output, 1, out_code holds a valid codeword.
- out_code, output, IP_BIT+4, encoded codeword (FIFO head).
- out_ready, input, 1, consumer takes out_code this cycle.
- word_cnt, output, 8, count of codewords popped, modulo 256.
- inj_en, input, 1, error-injection enable; used only with the optional feature.
- inj_pos, input, 4, error-injection position 1..N; used only with the optional feature.

Behaviour:
- Codeword layout: Hamming position p (1..N) maps to out_code[N-p], so position 1 is the MSB.
- Parity bits sit at positions 1, 2, 4 and 8.
- Data bits fill the remaining positions in ascending order, in_data MSB first (position 3 = in_data[IP_BIT-1]).
- Parity p_k (k = 1, 2, 4, 8), even parity: XOR of all data positions whose index has bit k set.
- Reset (async, rst_n=0):
  - FIFO emptied; count = 0.
  - out_valid = 0, out_code = 0, word_cnt = 0.
  - in_ready = 1 once rst_n is released.
- Reset asserted mid-transfer discards all buffered words.
- in_ready = (count != 2); combinational from count only, never from out_ready.
- Push: occurs when in_valid && in_ready.
  - The encoded codeword is written to the FIFO tail at that clock edge.
  - Earliest out_valid is the next cycle, so latency is 1 cycle.
- Pop: occurs when out_valid && out_ready.
  - The head advances at the edge and word_cnt increments (255 -> 0 wrap).
- Simultaneous push and pop:
  - count = 1: count stays 1, and the new word becomes head next cycle.
  - count = 0: pop is impossible.
  - count = 2: push is impossible.
- out_valid = (count != 0).
- out_code holds the head value while out_valid && !out_ready; it must not change until popped.
- When empty, out_code retains the last popped value; the bench must not check it.
- in_data is sampled only on push; changes while in_ready = 0 have no effect.
- Order preserved: first in, first out.
- Sustained throughput of 1 word/cycle when out_ready is held at 1.

Optional Feature:
- Macro: HAMMING_ERR_INJ_EN.
- Defined:
  - On push with inj_en = 1 and 1 <= inj_pos <= N, the stored codeword has Hamming position inj_pos inverted (bit out_code[N-inj_pos]).
  - inj_pos = 0 or inj_pos > N: no flip.
  - Used to exercise decoder single-error correction.
- Undefined: inj_en and inj_pos are ignored; no injection logic is synthesized.

Test Plan:
- Reset then single word, IP_BIT=5, in_data=5'b10110, out_ready=1 -> out_valid exactly one cycle after push, out_code=9'b011001100 (0x0CC), word_cnt=1.
- in_data=5'b11111, then 5'b00000 on back-to-back cycles, out_ready=1 -> out_code 0x0FF then 0x000 on consecutive cycles, in_ready held at 1.
- out_ready=0, push 3 words (0x01, 0x02, 0x03) -> in_ready drops to 0 after the second push; the third is accepted only after one pop. out_code order is enc(0x01), enc(0x02), enc(0x03), and the head is stable while stalled.
- Count=1 with simultaneous push and pop -> count stays 1, no word lost or duplicated; word_cnt wraps 255 -> 0 after the 256th pop.
- rst_n pulsed low mid-stream with 2 words buffered -> out_valid=0 and word_cnt=0 immediately (async), in_ready=1 after release.
- With HAMMING_ERR_INJ_EN, IP_BIT=5: in_data=5'b10110, inj_en=1, inj_pos=3 -> out_code=9'b010001100; feeding it through the decoder returns 5'b10110. inj_pos=0 -> 0x0CC unchanged.

Source files
------------

// File: rtl/hamming_enc_stream_if.sv
// -----------------------------------------------------------------------------
// hamming_enc_stream_if
//   Stream bundle for the Hamming encoder: an input word channel and an output
//   codeword channel, each with a valid/ready handshake.
//
//   Signals
//     in_valid  : producer has a data word this cycle
//     in_data   : data word, IP_BIT bits
//     in_ready  : encoder can accept a word this cycle
//     out_valid : out_code holds a valid codeword
//     out_code  : encoded codeword, IP_BIT+4 bits (FIFO head)
//     out_ready : consumer takes out_code this cycle
//
//   Modports
//     master : the side that feeds data words and consumes codewords
//     slave  : the encoder itself
// -----------------------------------------------------------------------------
interface hamming_enc_stream_if #(
    parameter int IP_BIT = 5
);
    localparam int N = IP_BIT + 4;

    logic              in_valid;
    logic [IP_BIT-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [N-1:0]      out_code;
    logic              out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_code
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_code
    );
endinterface

// File: rtl/hamming_enc_stream.sv
// -----------------------------------------------------------------------------
// hamming_enc_stream
//   Streaming single-error-correcting Hamming encoder. Each accepted IP_BIT-bit
//   word is encoded into an (IP_BIT+4)-bit codeword and written into a 2-entry
//   output FIFO, so the consumer can stall without stalling the encoder for
//   one extra word. Codeword format matches the team's Hamming decoder input.
//
//   Codeword layout: Hamming position p (1..N) is out_code[N-p], position 1 is
//   the MSB. Parity bits sit at positions 1, 2, 4, 8 (even parity); data bits
//   fill the other positions in ascending order, in_data MSB first.
//
//   Ports
//     clk      : clock, all state on rising edge
//     rst_n    : asynchronous active-low reset, empties the FIFO
//     bus      : hamming_enc_stream_if.slave (in/out valid-ready channels)
//     word_cnt : number of codewords popped, modulo 256
//     inj_en   : error-injection enable (optional feature only)
//     inj_pos  : error-injection Hamming position 1..N (optional feature only)
//
//   Optional feature, macro HAMMING_ERR_INJ_EN:
//     When defined, a push with inj_en=1 and 1 <= inj_pos <= N stores the
//     codeword with Hamming position inj_pos inverted. When undefined, inj_en
//     and inj_pos are ignored and no injection logic exists.
// -----------------------------------------------------------------------------
module hamming_enc_stream #(
    parameter int IP_BIT = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hamming_enc_stream_if.slave     bus,
    output logic [7:0]              word_cnt,
    input  logic                    inj_en,
    input  logic [3:0]              inj_pos
);
    localparam int N = IP_BIT + 4;

    // FIFO occupancy doubles as the control state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] head_q, tail_q;
    logic [N-1:0] enc_code;
    logic         push, pop;
    logic         head_from_new, head_from_tail, tail_from_new;

    // -------------------------------------------------------------------------
    // Encoder
    // -------------------------------------------------------------------------
    function automatic logic [N-1:0] encode(input logic [IP_BIT-1:0] data);
        logic [N-1:0] code;
        int           di;
        code = '0;
        di   = IP_BIT - 1;
        // Scatter data bits over the non-power-of-two positions, MSB first.
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                code[N-p] = data[di];
                di        = di - 1;
            end
        end
        // Each data position contributes to every parity position whose
        // index appears in its binary expansion.
        for (int p = 3; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (p[0]) code[N-1] = code[N-1] ^ code[N-p];
                if (p[1]) code[N-2] = code[N-2] ^ code[N-p];
                if (p[2]) code[N-4] = code[N-4] ^ code[N-p];
                if (p[3]) code[N-8] = code[N-8] ^ code[N-p];
            end
        end
        return code;
    endfunction

`ifdef HAMMING_ERR_INJ_EN
    always_comb begin
        enc_code = encode(bus.in_data);
        // Out-of-range positions (0 or > N) never match, so no flip occurs.
        for (int p = 1; p <= N; p++) begin
            if (inj_en && (inj_pos == 4'(p))) begin
                enc_code[N-p] = ~enc_code[N-p];
            end
        end
    end
`else
    assign enc_code = encode(bus.in_data);

    logic unused_inj;
    assign unused_inj = ^{inj_en, inj_pos};
`endif

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // in_ready depends on occupancy only, never on out_ready, so there is no
    // combinational path from the consumer back to the producer.
    assign bus.in_ready  = (state_q != ST_FULL);
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_code  = head_q;

    assign push = bus.in_valid  && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // -------------------------------------------------------------------------
    // Occupancy state machine
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is given a default first; a path that
    // left one unassigned would infer a latch.
    always_comb begin
        state_d        = state_q;
        head_from_new  = 1'b0;
        head_from_tail = 1'b0;
        tail_from_new  = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d       = ST_ONE;
                    head_from_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    // Head leaves, new word takes its place; occupancy stays 1.
                    head_from_new = 1'b1;
                end else if (push) begin
                    state_d       = ST_FULL;
                    tail_from_new = 1'b1;
                end else if (pop) begin
                    // Head keeps the popped value, so out_code holds it while empty.
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d        = ST_ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Storage and pop counter
    // -------------------------------------------------------------------------
    // NOTE: the two storage entries are reset because out_code must read zero
    // during reset; deeper buffers would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (head_from_new) begin
                head_q <= enc_code;
            end else if (head_from_tail) begin
                head_q <= tail_q;
            end
            if (tail_from_new) begin
                tail_q <= enc_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= 8'd0;
        end else if (pop) begin
            word_cnt <= word_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_hamming_enc_stream.sv
// -----------------------------------------------------------------------------
// tb_hamming_enc_stream
//   Self-checking bench for hamming_enc_stream with IP_BIT = 5 (N = 9).
//   A per-cycle vector table covers single word, back-to-back words and the
//   stall/full case; hand-written sequences cover sustained throughput with
//   word_cnt wrap, asynchronous reset with buffered words and error injection
//   (HAMMING_ERR_INJ_EN).
// -----------------------------------------------------------------------------
module tb_hamming_enc_stream;
    localparam int IP_BIT = 5;
    localparam int N      = IP_BIT + 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] word_cnt;
    logic       inj_en;
    logic [3:0] inj_pos;

    int checks;
    int errors;

    hamming_enc_stream_if #(.IP_BIT(IP_BIT)) bus ();

    hamming_enc_stream #(.IP_BIT(IP_BIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .word_cnt (word_cnt),
        .inj_en   (inj_en),
        .inj_pos  (inj_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One table row per cycle: inputs applied for the coming edge, and the
    // outputs expected before that edge. e_code is compared only when e_ov=1.
    typedef struct {
        logic       iv;
        logic [4:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [8:0] e_code;
        logic [7:0] e_wc;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoder for IP_BIT=5, written out position by position.
    function automatic logic [8:0] model_enc(input logic [4:0] d);
        logic d3, d5, d6, d7, d9, p1, p2, p4, p8;
        d3 = d[4]; d5 = d[3]; d6 = d[2]; d7 = d[1]; d9 = d[0];
        p1 = d3 ^ d5 ^ d7 ^ d9;
        p2 = d3 ^ d6 ^ d7;
        p4 = d5 ^ d6 ^ d7;
        p8 = d9;
        return {p1, p2, d3, p4, d5, d6, d7, p8, d9};
    endfunction

    // Reference single-error-correcting decoder for N=9.
    function automatic logic [4:0] model_dec(input logic [8:0] c);
        logic [3:0] syn;
        logic [8:0] fixed;
        syn   = 4'd0;
        fixed = c;
        for (int p = 1; p <= 9; p++) begin
            if (c[9-p]) syn = syn ^ 4'(p);
        end
        if (syn >= 4'd1 && syn <= 4'd9) fixed[9-int'(syn)] = ~fixed[9-int'(syn)];
        return {fixed[6], fixed[4], fixed[3], fixed[2], fixed[0]};
    endfunction

    // Push one word while stalled, check the stored codeword, then pop it.
    task automatic push_pop(input string name, input logic [4:0] d, input logic en,
                            input logic [3:0] pos, input logic [8:0] exp);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = d; bus.out_ready = 1'b0;
        inj_en = en; inj_pos = pos;
        @(negedge clk);
        bus.in_valid = 1'b0; inj_en = 1'b0; inj_pos = 4'd0; bus.out_ready = 1'b1;
        #1;
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_code"},  32'(bus.out_code),  32'(exp));
        check({name, "_decoded"}, 32'(model_dec(bus.out_code)), 32'(d));
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_wc;
        checks = 0;
        errors = 0;

        //           iv    d      ordy  e_ir  e_ov  e_code   e_wc
        // single word 10110
        vecs[0]  = '{1'b1, 5'h16, 1'b1, 1'b1, 1'b0, 9'h000, 8'd0};
        vecs[1]  = '{1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 9'h0CC, 8'd0};
        vecs[2]  = '{1'b0, 5'h00, 1'b1, 1'b1, 1'b0, 9'h000, 8'd1};
        // back-to-back 11111, 00000 with out_ready=1
        vecs[3]  = '{1'b1, 5'h1F, 1'b1, 1'b1, 1'b0, 9'h000, 8'd1};
        vecs[4]  = '{1'b1, 5'h00, 1'b1, 1'b1, 1'b1, 9'h0FF, 8'd1};
        vecs[5]  = '{1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 9'h000, 8'd2};
        vecs[6]  = '{1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 9'h000, 8'd3};
        // stalled consumer: 01, 02 fill the FIFO, 03 waits for a pop
        vecs[7]  = '{1'b1, 5'h01, 1'b0, 1'b1, 1'b0, 9'h000, 8'd3};
        vecs[8]  = '{1'b1, 5'h02, 1'b0, 1'b1, 1'b1, 9'h103, 8'd3};
        vecs[9]  = '{1'b1, 5'h03, 1'b0, 1'b0, 1'b1, 9'h103, 8'd3};
        vecs[10] = '{1'b1, 5'h03, 1'b0, 1'b0, 1'b1, 9'h103, 8'd3};
        vecs[11] = '{1'b1, 5'h03, 1'b1, 1'b0, 1'b1, 9'h103, 8'd3};
        vecs[12] = '{1'b1, 5'h03, 1'b0, 1'b1, 1'b1, 9'h1A4, 8'd4};
        // data changes while full must be ignored
        vecs[13] = '{1'b1, 5'h1F, 1'b0, 1'b0, 1'b1, 9'h1A4, 8'd4};
        vecs[14] = '{1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 9'h1A4, 8'd4};
        vecs[15] = '{1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 9'h0A7, 8'd5};
        vecs[16] = '{1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 9'h000, 8'd6};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        inj_en = 1'b0; inj_pos = 4'd0;
        #2;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_code",  32'(bus.out_code),  32'd0);
        check("reset_word_cnt",  32'(word_cnt),      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);

        // ---------------- vector table ----------------
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            bus.in_valid  = vecs[i].iv;
            bus.in_data   = vecs[i].d;
            bus.out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", i),  32'(bus.in_ready),  32'(vecs[i].e_ir));
            check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d_word_cnt", i),  32'(word_cnt),      32'(vecs[i].e_wc));
            if (vecs[i].e_ov) begin
                check($sformatf("vec%0d_out_code", i), 32'(bus.out_code), 32'(vecs[i].e_code));
            end
        end

        // ---------------- sustained throughput and word_cnt wrap ----------------
        // Six pops so far; 250 more bring the total to 256.
        exp_wc = 8'd6;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_data = 5'(k); bus.out_ready = 1'b1;
            #1;
            check("stream_in_ready", 32'(bus.in_ready), 32'd1);
            if (k > 0) begin
                check("stream_out_valid", 32'(bus.out_valid), 32'd1);
                check("stream_out_code",  32'(bus.out_code),  32'(model_enc(5'(k - 1))));
                check("stream_word_cnt",  32'(word_cnt),      32'(exp_wc));
                exp_wc = exp_wc + 8'd1;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("stream_last_code", 32'(bus.out_code), 32'(model_enc(5'(249))));
        check("stream_cnt_255",   32'(word_cnt),     32'd255);
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        check("wrap_word_cnt",  32'(word_cnt),      32'd0);
        check("wrap_out_valid", 32'(bus.out_valid), 32'd0);

        // ---------------- async reset with two words buffered ----------------
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 5'h07; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 5'h08; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 5'h09; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("pre_rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_word_cnt",  32'(word_cnt),      32'd1);
        check("pre_rst_out_code",  32'(bus.out_code),  32'(model_enc(5'h08)));
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_word_cnt",  32'(word_cnt),      32'd0);
        check("mid_rst_out_code",  32'(bus.out_code),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        #1;
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        // ---------------- error injection ----------------
`ifdef HAMMING_ERR_INJ_EN
        push_pop("inj_pos3",  5'h16, 1'b1, 4'd3,  9'h08C);
        push_pop("inj_pos0",  5'h16, 1'b1, 4'd0,  9'h0CC);
        push_pop("inj_pos10", 5'h16, 1'b1, 4'd10, 9'h0CC);
        push_pop("inj_pos9",  5'h16, 1'b1, 4'd9,  9'h0CD);
        push_pop("inj_off",   5'h16, 1'b0, 4'd3,  9'h0CC);
`else
        push_pop("inj_ignored", 5'h16, 1'b1, 4'd3, 9'h0CC);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
